// File: rtl/apb_master_arbiter.sv
// Two-requester APB master front-end: round-robin arbitration, registered
// command, APB setup/access sequencing and a pready timeout.
module apb_master_arbiter #(
  parameter int unsigned TIMEOUT = 32'd16,
  parameter int unsigned CNT_W   = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_write,
  input  logic [15:0] m0_wdata,
  output logic        m0_done,
  output logic [15:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_write,
  input  logic [15:0] m1_wdata,
  output logic        m1_done,
  output logic [15:0] m1_rdata,
  output logic        m1_err,
  output logic [15:0] paddr,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  output logic [15:0] pwdata,
  input  logic [15:0] prdata,
  input  logic        pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic             TO_EN   = (TIMEOUT != 32'd0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_t           state_r;
  logic             last_grant_r;
  logic             owner_r;
  logic [CNT_W-1:0] cnt_r;

  logic             any_req_s;
  logic             pick1_s;
  logic             timeout_s;
  logic [15:0]      rd_s;

  // Arbitration pick, read-data selection and timeout detection.
  always_comb begin
    any_req_s = m0_req | m1_req;
    // On a tie the requester that did not win last time goes next.
    if (m0_req && m1_req) begin
      pick1_s = ~last_grant_r;
    end else begin
      pick1_s = m1_req;
    end
    if (pwrite) begin
      rd_s = 16'h0000;
    end else begin
      rd_s = prdata;
    end
    timeout_s = TO_EN && (cnt_r == TO_LAST);
  end

  // Transaction FSM with all APB and requester outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      cnt_r        <= '0;
      paddr        <= 16'h0000;
      pwrite       <= 1'b0;
      pwdata       <= 16'h0000;
      psel         <= 1'b0;
      penable      <= 1'b0;
      m0_done      <= 1'b0;
      m0_rdata     <= 16'h0000;
      m0_err       <= 1'b0;
      m1_done      <= 1'b0;
      m1_rdata     <= 16'h0000;
      m1_err       <= 1'b0;
    end else begin
      m0_done  <= 1'b0;
      m0_rdata <= 16'h0000;
      m0_err   <= 1'b0;
      m1_done  <= 1'b0;
      m1_rdata <= 16'h0000;
      m1_err   <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r   <= '0;
          penable <= 1'b0;
          if (any_req_s) begin
            owner_r      <= pick1_s;
            last_grant_r <= pick1_s;
            paddr        <= pick1_s ? m1_addr  : m0_addr;
            pwrite       <= pick1_s ? m1_write : m0_write;
            pwdata       <= pick1_s ? m1_wdata : m0_wdata;
            psel         <= 1'b1;
            state_r      <= SETUP;
          end else begin
            psel <= 1'b0;
          end
        end
        SETUP: begin
          psel    <= 1'b1;
          penable <= 1'b1;
          state_r <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle.
          if (pready) begin
            cnt_r   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            state_r <= DONE;
            if (owner_r) begin
              m1_done  <= 1'b1;
              m1_rdata <= rd_s;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= rd_s;
            end
          end else if (timeout_s) begin
            cnt_r   <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            state_r <= DONE;
            if (owner_r) begin
              m1_done <= 1'b1;
              m1_err  <= 1'b1;
            end else begin
              m0_done <= 1'b1;
              m0_err  <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        DONE: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-timeline model.
module tb_apb_master_arbiter;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
  logic [15:0] m0_addr = 16'h0000, m0_wdata = 16'h0000, m1_addr = 16'h0000, m1_wdata = 16'h0000;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] paddr, pwdata;
  logic        pwrite, psel, penable;
  logic [15:0] prdata = 16'h0000;
  logic        pready = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        who;
    logic [15:0] addr;
    logic        write;
    logic [15:0] wdata;
    int          wait_n;
    logic [15:0] rd;
    int          exp_done;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_pen;
  } vec_t;

  apb_master_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    pready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One isolated transaction; the slave counts ACCESS cycles seen on the bus.
  task automatic run_vec(input vec_t v, input int idx);
    int          done_at, psel_at, pen_at, pen_n, acc;
    logic [15:0] got_rd;
    logic        got_err, wrong, cmd_ok;
    done_at = -1; psel_at = -1; pen_at = -1; pen_n = 0; acc = 0;
    got_rd = 16'h0000; got_err = 1'b0; wrong = 1'b0; cmd_ok = 1'b1;
    pready = 1'b0;
    if (v.who) begin
      m1_req = 1'b1; m1_addr = v.addr; m1_write = v.write; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_addr = v.addr; m0_write = v.write; m0_wdata = v.wdata;
    end
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      step();
      if (k == 1) begin
        // scramble the command right after grant; the bus must not follow
        if (v.who) begin
          m1_req = 1'b0; m1_addr = ~v.addr; m1_write = ~v.write; m1_wdata = ~v.wdata;
        end else begin
          m0_req = 1'b0; m0_addr = ~v.addr; m0_write = ~v.write; m0_wdata = ~v.wdata;
        end
      end
      if (psel && psel_at < 0) psel_at = k;
      if (penable && pen_at < 0) pen_at = k;
      if (penable) pen_n++;
      if (psel && (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata)) cmd_ok = 1'b0;
      if (v.who ? m0_done : m1_done) wrong = 1'b1;
      if (v.who ? m1_done : m0_done) begin
        done_at = k;
        got_rd  = v.who ? m1_rdata : m0_rdata;
        got_err = v.who ? m1_err : m0_err;
      end
      if (psel && penable) begin
        pready = (acc == v.wait_n);
        prdata = pready ? v.rd : 16'($urandom);
        acc++;
      end else begin
        pready = 1'b0;
        prdata = 16'($urandom);
      end
    end
    pready = 1'b0;
    chk($sformatf("vec%0d_psel_cycle", idx), 64'(psel_at), 64'd1);
    chk($sformatf("vec%0d_penable_cycle", idx), 64'(pen_at), 64'd2);
    chk($sformatf("vec%0d_done_cycle", idx), 64'(done_at), 64'(v.exp_done));
    chk($sformatf("vec%0d_rdata", idx), 64'(got_rd), 64'(v.exp_rdata));
    chk($sformatf("vec%0d_err", idx), 64'(got_err), 64'(v.exp_err));
    chk($sformatf("vec%0d_penable_len", idx), 64'(pen_n), 64'(v.exp_pen));
    chk($sformatf("vec%0d_cmd_stable", idx), 64'(cmd_ok), 64'd1);
    chk($sformatf("vec%0d_other_done", idx), 64'(wrong), 64'd0);
    step();
    chk($sformatf("vec%0d_one_pulse", idx), {62'd0, m0_done, m1_done}, 64'd0);
    chk($sformatf("vec%0d_addr_hold", idx), 64'(paddr), 64'(v.addr));
  endtask

  initial begin
    vec_t vecs[7];
    int   n_done;
    int   done_cyc[3];
    logic [1:0]  done_who[3];
    logic [15:0] done_rd[3];
    logic        done_err[3];
    int   m0_seen, m1_at;

    vecs[0] = '{1'b0, 16'h4010, 1'b1, 16'hBEEF, 0,  16'h0000, 3,  16'h0000, 1'b0, 1};
    vecs[1] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 0,  16'h1234, 3,  16'h1234, 1'b0, 1};
    vecs[2] = '{1'b1, 16'h7FFF, 1'b0, 16'h0F0F, 5,  16'h00A5, 8,  16'h00A5, 1'b0, 6};
    vecs[3] = '{1'b0, 16'h8000, 1'b0, 16'h0000, 99, 16'hFFFF, 18, 16'h0000, 1'b1, 16};
    vecs[4] = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 0,  16'h5A5A, 3,  16'h5A5A, 1'b0, 1};
    vecs[5] = '{1'b1, 16'hFFFF, 1'b1, 16'h1357, 2,  16'h7777, 5,  16'h0000, 1'b0, 3};
    vecs[6] = '{1'b0, 16'h1111, 1'b0, 16'h2222, 15, 16'hC0DE, 18, 16'hC0DE, 1'b0, 16};

    do_reset();
    chk("rst_ctl", {57'd0, psel, penable, pwrite, m0_done, m1_done, m0_err, m1_err}, 64'd0);
    chk("rst_data", {paddr, pwdata, m0_rdata, m1_rdata}, 64'd0);

    // Both requesters hold read requests: m0, m1, m0 four cycles apart.
    m0_req = 1'b1; m0_addr = 16'h0100; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0200; m1_write = 1'b0;
    prdata = 16'h1234; pready = 1'b1;
    n_done = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (m0_done || m1_done) begin
        if (n_done < 3) begin
          done_cyc[n_done] = k;
          done_who[n_done] = {m1_done, m0_done};
          done_rd[n_done]  = m1_done ? m1_rdata : m0_rdata;
          done_err[n_done] = m0_err | m1_err;
        end
        n_done++;
        if (n_done == 3) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
      end
    end
    pready = 1'b0;
    chk("rr_count", 64'(n_done), 64'd3);
    for (int i = 0; i < 3 && i < n_done; i++) begin
      chk($sformatf("rr%0d_cycle", i), 64'(done_cyc[i]), 64'(3 + 4 * i));
      chk($sformatf("rr%0d_who", i), 64'(done_who[i]), (i == 1) ? 64'd2 : 64'd1);
      chk($sformatf("rr%0d_rdata", i), 64'(done_rd[i]), 64'h1234);
      chk($sformatf("rr%0d_err", i), 64'(done_err[i]), 64'd0);
    end

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      step();
    end

    // Reset during ACCESS: transaction lost, m1 served after release.
    pready = 1'b0;
    m0_req = 1'b1; m0_addr = 16'h2222; m0_write = 1'b0;
    step();
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 16'h3333; m1_write = 1'b0;
    step();
    chk("rstacc_penable", 64'(penable), 64'd1);
    reset = 1'b1;
    step();
    chk("rstacc_bus", {62'd0, psel, penable}, 64'd0);
    chk("rstacc_done", {62'd0, m0_done, m1_done}, 64'd0);
    step();
    reset = 1'b0;
    pready = 1'b1; prdata = 16'h4321;
    m0_seen = 0; m1_at = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (m0_done) m0_seen++;
      if (m1_done && m1_at < 0) begin
        m1_at = k;
        m1_req = 1'b0;
        chk("rstacc_m1_rdata", 64'(m1_rdata), 64'h4321);
      end
    end
    pready = 1'b0;
    chk("rstacc_m1_cycle", 64'(m1_at), 64'd3);
    chk("rstacc_no_m0", 64'(m0_seen), 64'd0);

    // Randomized traffic against a transaction-timeline model.
    begin
      logic        r_req[2];
      logic [15:0] r_addr[2];
      logic        r_write[2];
      logic [15:0] r_wdata[2];
      logic        m_lg, own, act, have_cmd, done_now, exp_err, c_write;
      logic [15:0] c_addr, c_wdata, exp_rd;
      int          g, d, w, free_at;
      logic        e_psel, e_pen, e_d0, e_d1;

      do_reset();
      m_lg = 1'b1; act = 1'b0; have_cmd = 1'b0; own = 1'b0; exp_err = 1'b0;
      g = 0; d = 0; w = 0; free_at = 0;
      c_addr = 16'h0000; c_wdata = 16'h0000; c_write = 1'b0; exp_rd = 16'h0000;
      for (int x = 0; x < 2; x++) begin
        r_req[x] = 1'b0; r_addr[x] = 16'h0000; r_write[x] = 1'b0; r_wdata[x] = 16'h0000;
      end
      for (int t = 0; t < 1500; t++) begin
        e_psel = act && t >= g + 1 && t < d;
        e_pen  = act && t >= g + 2 && t < d;
        e_d0   = act && t == d && !own;
        e_d1   = act && t == d && own;
        chk("rnd_ctl", {58'd0, psel, penable, m0_done, m1_done, m0_err, m1_err},
            {58'd0, e_psel, e_pen, e_d0, e_d1, e_d0 && exp_err, e_d1 && exp_err});
        chk("rnd_rdata", {32'd0, m0_rdata, m1_rdata},
            {32'd0, e_d0 ? exp_rd : 16'h0000, e_d1 ? exp_rd : 16'h0000});
        if (have_cmd)
          chk("rnd_cmd", {31'd0, paddr, pwrite, pwdata}, {31'd0, c_addr, c_write, c_wdata});

        done_now = act && t == d;
        for (int x = 0; x < 2; x++) begin
          if (act && own == x[0] && t == g + 1) begin
            r_addr[x] = 16'($urandom); r_write[x] = 1'($urandom); r_wdata[x] = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r_req[x] = 1'b0;
          end else if (!r_req[x]) begin
            if ($urandom_range(0, 2) == 0) begin
              r_req[x] = 1'b1;
              r_addr[x] = 16'($urandom); r_write[x] = 1'($urandom); r_wdata[x] = 16'($urandom);
            end
          end else if (done_now && own == x[0]) begin
            if ($urandom_range(0, 1) == 0) r_req[x] = 1'b0;
            else begin
              r_addr[x] = 16'($urandom); r_write[x] = 1'($urandom); r_wdata[x] = 16'($urandom);
            end
          end
        end
        if (done_now) act = 1'b0;

        if (!act && t >= free_at && (r_req[0] || r_req[1])) begin
          own     = (r_req[0] && r_req[1]) ? !m_lg : r_req[1];
          m_lg    = own;
          g       = t;
          c_addr  = r_addr[own]; c_write = r_write[own]; c_wdata = r_wdata[own];
          w       = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
          exp_err = (w >= TIMEOUT);
          d       = exp_err ? g + 2 + TIMEOUT : g + 3 + w;
          exp_rd  = 16'h0000;
          free_at = d + 1;
          act     = 1'b1;
          have_cmd = 1'b1;
        end

        if (act && !exp_err && t == g + 2 + w) begin
          pready = 1'b1;
          prdata = 16'($urandom);
          exp_rd = c_write ? 16'h0000 : prdata;
        end else if (act && t >= g + 2 && t < d) begin
          pready = 1'b0;
          prdata = 16'($urandom);
        end else begin
          pready = 1'($urandom);
          prdata = 16'($urandom);
        end

        m0_req = r_req[0]; m0_addr = r_addr[0]; m0_write = r_write[0]; m0_wdata = r_wdata[0];
        m1_req = r_req[1]; m1_addr = r_addr[1]; m1_write = r_write[1]; m1_wdata = r_wdata[1];
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
